down_counter: RTL and testbench
===============================

Name: down_counter

Overview:
- Loadable down-counter, the count-down counterpart of the team's 8-bit up counter.
- Software or control logic loads a start value. The block decrements once per enabled clock and flags terminal count when it reaches zero.
- Used as a programmable delay/timeout generator next to the up counter in the same clock domain.

Parameters:
- WIDTH, 8, bit width of the count, the load value and the reload register.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  count enable; decrement only when high and in RUN.
- clear  input  1  synchronous abort; returns block to IDLE with out=0.
- load  input  1  load strobe; captures load_val into out and into the reload register.
- load_val  input  WIDTH  start value for the count.
- out  output  WIDTH  current count, registered.
- zero  output  1  combinational, high when out==0.
- busy  output  1  registered, high while in RUN.
- tc_pulse  output  1  registered, one-cycle pulse on terminal count.

Behaviour:
- One clock. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - out=0, reload register=0, state=IDLE.
  - busy=0, tc_pulse=0; zero therefore 1.
- Priority per edge: reset > clear > load > enable.
- tc_pulse defaults to 0 every cycle unless set by a rule below, so it is never high two cycles in a row from the same event.
- States:
  - IDLE: out holds; enable is ignored.
  - RUN: counting.
  - DONE: out holds 0; enable is ignored.
- load, any state:
  - out<=load_val and reload<=load_val on the same edge.
  - If load_val!=0: next state RUN, busy=1.
  - If load_val==0: next state DONE, tc_pulse=1 on that edge (a zero load terminates immediately).
- RUN, enable=1, out>1: out<=out-1 (latency 1 clk per step).
- RUN, enable=1, out==1: terminal count. out<=0, state<=DONE, busy<=0, tc_pulse<=1. The pulse is coincident with out becoming 0.
- RUN, enable=0: out, state and outputs hold; no pulse.
- clear, any state: out<=0, state<=IDLE, busy<=0, tc_pulse<=0. The reload register is kept.
- Simultaneous load+enable: load wins; no decrement that edge. The first decrement occurs on the next enabled edge.
- Simultaneous clear+load: clear wins; load_val is discarded.
- Arithmetic: unsigned, modulo 2^WIDTH. Underflow is impossible because decrement never occurs from 0. A load of all-ones counts 2^WIDTH-1 enabled edges to terminal count.
- Reset mid-count: next edge returns to the reset values above regardless of enable/load.
- Terminal-count spacing: after load of N (N>0), tc_pulse occurs exactly N enabled edges later.

Optional Feature:
- Macro: DOWN_COUNTER_AUTO_RELOAD_EN.
- Defined, RUN with enable=1 and out==1:
  - out<=reload, state stays RUN, busy stays 1, tc_pulse<=1.
  - Result: periodic pulse every N enabled edges.
  - If reload==1, tc_pulse fires on every enabled edge.
  - DONE is reached only via a zero load.
- Not defined: terminal count goes to DONE exactly as above; the reload register is still written but unused for counting.

Test Plan:
- reset=1 for 3 edges, with load=1, load_val=8'h20 driven -> out=0, zero=1, busy=0, tc_pulse=0 after each edge.
- load 8'd5, then enable=1 held -> out sequence 5,4,3,2,1,0. tc_pulse high only on the edge where out becomes 0; busy falls the same edge; out stays 0 for 10 more cycles.
- load 8'd4, enable toggled 1,0,1,0,... -> out decrements only on enable=1 edges. tc_pulse is asserted 4 enabled edges after the load.
- load 8'd10, enable=1, assert clear when out==6 -> next edge out=0, state IDLE, busy=0, no tc_pulse. A subsequent enable causes no change.
- load=1, enable=1 on the same edge with load_val=8'd3 -> out=3 (not 2); next enabled edge out=2. Separately, load_val=0 -> tc_pulse one cycle and busy=0.
- With DOWN_COUNTER_AUTO_RELOAD_EN defined: load 8'd3, enable=1 for 12 edges -> out 3,2,1,3,2,1,... with tc_pulse on every 3rd enabled edge (4 pulses), and busy constantly 1.

Source files
------------

// File: rtl/down_counter.sv
// -----------------------------------------------------------------------------
// down_counter
//
// Loadable down-counter used as a programmable delay / timeout generator.
// A start value is loaded with `load`. The counter then decrements once per
// enabled clock while in RUN. When it steps from 1 to 0 it raises a one-cycle
// terminal-count pulse and parks in DONE.
//
// Optional feature (compile-time macro DOWN_COUNTER_AUTO_RELOAD_EN):
//   When defined, terminal count reloads the last loaded value and stays in
//   RUN. This gives a periodic tc_pulse every N enabled edges. With the macro
//   undefined, terminal count goes to DONE. The reload register is still
//   written on every load, but nothing reads it for counting.
//
// Parameters:
//   WIDTH     bit width of the count, the load value and the reload register
//
// Ports:
//   clk       system clock, all logic on the rising edge
//   reset     synchronous, active-high reset
//   enable    count enable (only effective in RUN)
//   clear     synchronous abort: back to IDLE with out = 0, reload kept
//   load      load strobe: out and reload take load_val
//   load_val  start value
//   out       current count (registered)
//   zero      high when out == 0 (combinational from the out register)
//   busy      high while in RUN (registered)
//   tc_pulse  one-cycle terminal-count pulse (registered)
//
// Priority on each edge: reset > clear > load > enable.
// -----------------------------------------------------------------------------
module down_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             busy,
  output logic             tc_pulse
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_s;
  logic [WIDTH-1:0] reload_r;
  logic [WIDTH-1:0] reload_s;
  logic             busy_r;
  logic             busy_s;
  logic             tc_r;
  logic             tc_s;

  // Terminal-count step: the action taken when RUN sees an enabled edge with
  // out == 1. It is split out so the build-time choice stays in one place.
  logic [WIDTH-1:0] tc_count_s;
  state_t           tc_state_s;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  // Auto-reload: restart from the last loaded value and keep running.
  always_comb begin
    tc_count_s = reload_r;
    tc_state_s = ST_RUN;
  end
`else
  // One-shot: land on zero and stop.
  always_comb begin
    tc_count_s = CNT_ZERO;
    tc_state_s = ST_DONE;
  end
`endif

  // Next-state, next-count and pulse logic. Reset is applied in the register
  // process, so this block handles clear > load > enable.
  always_comb begin
    state_s  = state_r;
    count_s  = count_r;
    reload_s = reload_r;
    tc_s     = 1'b0;

    if (clear) begin
      // Abort. The reload value survives so software can inspect or re-use it.
      state_s = ST_IDLE;
      count_s = CNT_ZERO;
    end else if (load) begin
      count_s  = load_val;
      reload_s = load_val;
      if (load_val == CNT_ZERO) begin
        // A zero load has nothing to count, so it terminates at once.
        state_s = ST_DONE;
        tc_s    = 1'b1;
      end else begin
        state_s = ST_RUN;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_s = ST_IDLE;
        end
        ST_RUN: begin
          if (enable) begin
            if (count_r == CNT_ONE) begin
              state_s = tc_state_s;
              count_s = tc_count_s;
              tc_s    = 1'b1;
            end else if (count_r == CNT_ZERO) begin
              // Unreachable in normal operation, because RUN is only entered
              // with a non-zero count. Stop instead of wrapping to all-ones.
              state_s = ST_DONE;
              count_s = CNT_ZERO;
            end else begin
              count_s = count_r - CNT_ONE;
            end
          end else begin
            state_s = ST_RUN;
          end
        end
        ST_DONE: begin
          state_s = ST_DONE;
          count_s = CNT_ZERO;
        end
        default: begin
          // Illegal encoding: fall back to a safe, quiescent state.
          state_s = ST_IDLE;
          count_s = CNT_ZERO;
        end
      endcase
    end

    // busy is registered, so it follows the state being entered.
    if (state_s == ST_RUN) begin
      busy_s = 1'b1;
    end else begin
      busy_s = 1'b0;
    end
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      count_r  <= CNT_ZERO;
      reload_r <= CNT_ZERO;
      busy_r   <= 1'b0;
      tc_r     <= 1'b0;
    end else begin
      state_r  <= state_s;
      count_r  <= count_s;
      reload_r <= reload_s;
      busy_r   <= busy_s;
      tc_r     <= tc_s;
    end
  end

  assign out      = count_r;
  assign zero     = (count_r == CNT_ZERO);
  assign busy     = busy_r;
  assign tc_pulse = tc_r;

endmodule

// File: tb/tb_down_counter.sv
// Testbench for down_counter. The stimulus side updates a behavioural model
// and queues the expected outputs for the next edge. A monitor pops the queue
// one time unit after each rising edge and compares the DUT against it.
module tb_down_counter;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         enable;
  logic         clear;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] out;
  logic         zero;
  logic         busy;
  logic         tc_pulse;

  down_counter #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .clear    (clear),
    .load     (load),
    .load_val (load_val),
    .out      (out),
    .zero     (zero),
    .busy     (busy),
    .tc_pulse (tc_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned out;
    bit          busy;
    bit          tc;
    int          step;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int step_no  = 0;

  // Reference model, kept as plain integers.
  int unsigned m_count  = 0;
  int unsigned m_reload = 0;
  bit          m_active = 0;  // counting in progress
  bit          m_tc     = 0;

  task automatic check(input string name, input int unsigned got, input int unsigned want, input int step);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s (step %0d): got %0d, expected %0d", name, step, got, want);
    end
  endtask

  // Model of one clock edge, written from the behavioural rules.
  task automatic model_edge(input bit r, input bit c, input bit l, input int unsigned v, input bit e);
    m_tc = 0;
    if (r) begin
      m_count = 0; m_reload = 0; m_active = 0;
    end else if (c) begin
      m_count = 0; m_active = 0;
    end else if (l) begin
      m_count  = v;
      m_reload = v;
      m_active = (v != 0);
      m_tc     = (v == 0);
    end else if (m_active && e) begin
      if (m_count == 1) begin
        m_tc = 1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        m_count = m_reload;
`else
        m_count  = 0;
        m_active = 0;
`endif
      end else begin
        m_count = m_count - 1;
      end
    end
  endtask

  // Drive one cycle of stimulus at the falling edge and queue its expectation.
  task automatic step(input bit r, input bit c, input bit l, input logic [W-1:0] v, input bit e);
    exp_t x;
    @(negedge clk);
    reset    = r;
    clear    = c;
    load     = l;
    load_val = v;
    enable   = e;
    model_edge(r, c, l, int'(v), e);
    step_no++;
    x.out  = m_count;
    x.busy = m_active;
    x.tc   = m_tc;
    x.step = step_no;
    exp_q.push_back(x);
  endtask

  // Monitor: the DUT presents a fresh output after every rising edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      check("out",      int'(out),      x.out,                   x.step);
      check("zero",     int'(zero),     (x.out == 0) ? 1 : 0,    x.step);
      check("busy",     int'(busy),     x.busy ? 1 : 0,          x.step);
      check("tc_pulse", int'(tc_pulse), x.tc ? 1 : 0,            x.step);
    end
  end

  initial begin
    reset = 1'b0; clear = 1'b0; load = 1'b0; enable = 1'b0; load_val = '0;

    // Reset wins over a simultaneous load.
    repeat (3) step(1'b1, 1'b0, 1'b1, 8'h20, 1'b0);

    // Load 5 with enable held, then dwell in DONE.
    step(1'b0, 1'b0, 1'b1, 8'd5, 1'b0);
    repeat (15) step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);

    // Load 4 with enable toggling.
    step(1'b0, 1'b0, 1'b1, 8'd4, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 8'd0, (i % 2) == 0);

    // Load 10, clear when out reaches 6, then enable has no effect.
    step(1'b0, 1'b0, 1'b1, 8'd10, 1'b0);
    repeat (4) step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 8'd0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);

    // Load and enable on the same edge: no decrement on that edge.
    step(1'b0, 1'b0, 1'b1, 8'd3, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    // Clear and load on the same edge: clear wins.
    step(1'b0, 1'b1, 1'b1, 8'd7, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    // A zero load terminates at once.
    step(1'b0, 1'b0, 1'b1, 8'd0, 1'b1);
    repeat (2) step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);

    // Reset in the middle of a count.
    step(1'b0, 1'b0, 1'b1, 8'd9, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 8'd4, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);

    // All-ones load: 255 enabled edges to terminal count.
    step(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0);
    repeat (258) step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);

    // Auto-reload period (the model follows the build choice).
    step(1'b0, 1'b0, 1'b1, 8'd3, 1'b0);
    repeat (12) step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    // Reload value of 1.
    step(1'b0, 1'b0, 1'b1, 8'd1, 1'b0);
    repeat (4) step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);

    // Randomised traffic, biased towards short counts.
    for (int i = 0; i < 3000; i++) begin
      bit r, c, l, e;
      logic [W-1:0] v;
      r = ($urandom_range(0, 99) < 2);
      c = ($urandom_range(0, 99) < 4);
      l = ($urandom_range(0, 99) < 8);
      e = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 1) == 0) v = W'($urandom_range(0, 7));
      else                           v = W'($urandom);
      step(r, c, l, v, e);
    end

    // Drain the scoreboard.
    @(negedge clk);
    reset = 1'b0; clear = 1'b0; load = 1'b0; enable = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 0, step_no);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
